// File: rtl/flow_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flow_ctrl_pkg
// Description : Shared definitions for the pipeline flow-control unit.
//               - FSM state encoding (FC_IDLE / FC_MEM_WAIT)
//               - data-memory direction encodings
//               - architectural zero-register index
// Revision    : 1.0 - initial release
// ============================================================================
package flow_ctrl_pkg;

  typedef enum logic [0:0] {
    FC_IDLE     = 1'b0,
    FC_MEM_WAIT = 1'b1
  } fc_state_e;

  localparam logic       MEM_RW_LOAD  = 1'b0;
  localparam logic       MEM_RW_STORE = 1'b1;
  localparam logic [4:0] ZERO_REG_IDX = 5'd0;

endpackage : flow_ctrl_pkg
`default_nettype wire

// File: rtl/flow_ctrl_load_use_det.sv
`default_nettype none
// ============================================================================
// Module      : fc_load_use_det
// Description : Combinational load-use hazard detector. Flags when the
//               instruction in ID reads a register that the load currently
//               in ID/EX will write.
// Ports       : i_rs1_addr/i_rs1_re, i_rs2_addr/i_rs2_re - ID source operands
//               i_waddr   - destination of the ID/EX instruction
//               i_mtype   - ID/EX instruction is a memory op
//               i_mem_rw  - ID/EX memory direction (load / store)
//               o_hazard  - load-use hazard present
// Revision    : 1.0 - initial release
// ============================================================================
module fc_load_use_det
  import flow_ctrl_pkg::*;
(
  input  logic [4:0] i_rs1_addr,
  input  logic       i_rs1_re,
  input  logic [4:0] i_rs2_addr,
  input  logic       i_rs2_re,
  input  logic [4:0] i_waddr,
  input  logic       i_mtype,
  input  logic       i_mem_rw,
  output logic       o_hazard
);

  logic w_is_load;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // Writes to x0 are discarded, so they can never create a dependency.
  assign w_is_load = i_mtype && (i_mem_rw == MEM_RW_LOAD) && (i_waddr != ZERO_REG_IDX);
  assign w_rs1_hit = i_rs1_re && (i_rs1_addr == i_waddr);
  assign w_rs2_hit = i_rs2_re && (i_rs2_addr == i_waddr);
  assign o_hazard  = w_is_load && (w_rs1_hit || w_rs2_hit);

endmodule : fc_load_use_det
`default_nettype wire

// File: rtl/flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : flow_ctrl
// Description : Pipeline flow-control unit. Produces hold (bk) and flush
//               controls for pc_reg / if_id_reg / id_ex_reg / ex_mem_reg,
//               plus a redirect PC, from load-use hazards, EX-resolved
//               jumps and data-memory wait cycles (with timeout abort).
// Ports       : clk, rst (sync, active high)
//               id_rs*_i, idex_*_i  - hazard detection inputs
//               ex_jump_i/ex_jump_pc_i - taken branch/jump from EX
//               mem_req_i/mem_ack_i  - data-memory handshake
//               fc_bk_*_o, fc_flush_*_o, fc_jump_*_o - pipeline controls
//               fc_mem_err_o         - one-cycle memory-timeout pulse
//               fc_stall_cnt_o / fc_flush_cnt_o - performance counters
// Config      : FC_PERF_CNT_EN - when defined, enables the stall/flush
//               performance counters; otherwise both ports read 32'h0.
// Revision    : 1.0 - initial release
// ============================================================================
module flow_ctrl
  import flow_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic        id_rs1_re_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs2_re_i,
  input  logic [4:0]  idex_reg_waddr_i,
  input  logic        idex_mtype_i,
  input  logic        idex_mem_rw_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_jump_pc_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        fc_bk_pc_o,
  output logic        fc_bk_ifid_o,
  output logic        fc_bk_idex_o,
  output logic        fc_bk_exmem_o,
  output logic        fc_flush_ifid_o,
  output logic        fc_flush_idex_o,
  output logic        fc_flush_exmem_o,
  output logic        fc_jump_flag_o,
  output logic [31:0] fc_jump_pc_o,
  output logic        fc_mem_err_o,
  output logic [31:0] fc_stall_cnt_o,
  output logic [31:0] fc_flush_cnt_o
);

  localparam logic [TO_W-1:0] C_TIMEOUT = TO_W'(MEM_TIMEOUT);

  fc_state_e       r_state;
  logic [TO_W-1:0] r_to_cnt;

  logic w_load_use;
  logic w_mem_stall;
  logic w_timeout;

  fc_load_use_det u_load_use_det (
    .i_rs1_addr (id_rs1_addr_i),
    .i_rs1_re   (id_rs1_re_i),
    .i_rs2_addr (id_rs2_addr_i),
    .i_rs2_re   (id_rs2_re_i),
    .i_waddr    (idex_reg_waddr_i),
    .i_mtype    (idex_mtype_i),
    .i_mem_rw   (idex_mem_rw_i),
    .o_hazard   (w_load_use)
  );

  assign w_timeout   = (r_state == FC_MEM_WAIT) && (r_to_cnt == C_TIMEOUT) && !mem_ack_i;
  assign w_mem_stall = ((r_state == FC_IDLE) && mem_req_i && !mem_ack_i) ||
                       ((r_state == FC_MEM_WAIT) && !mem_ack_i);

  // State and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= FC_IDLE;
      r_to_cnt <= '0;
    end else begin
      case (r_state)
        FC_IDLE: begin
          if (mem_req_i && !mem_ack_i) begin
            r_state  <= FC_MEM_WAIT;
            r_to_cnt <= TO_W'(1);
          end
        end
        FC_MEM_WAIT: begin
          if (mem_ack_i || (r_to_cnt == C_TIMEOUT)) begin
            r_state  <= FC_IDLE;
            r_to_cnt <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        default: begin
          r_state  <= FC_IDLE;
          r_to_cnt <= '0;
        end
      endcase
    end
  end

  // Prioritised control decode. Timeout preempts the stall it would
  // otherwise extend; a frozen EX stage means jumps wait for release.
  always_comb begin
    fc_bk_pc_o       = 1'b0;
    fc_bk_ifid_o     = 1'b0;
    fc_bk_idex_o     = 1'b0;
    fc_bk_exmem_o    = 1'b0;
    fc_flush_ifid_o  = 1'b0;
    fc_flush_idex_o  = 1'b0;
    fc_flush_exmem_o = 1'b0;
    fc_jump_flag_o   = 1'b0;
    fc_jump_pc_o     = 32'h0;
    fc_mem_err_o     = 1'b0;
    if (rst) begin
      // everything held at zero
    end else if (w_timeout) begin
      fc_mem_err_o     = 1'b1;
      fc_flush_exmem_o = 1'b1;
    end else if (w_mem_stall) begin
      fc_bk_pc_o    = 1'b1;
      fc_bk_ifid_o  = 1'b1;
      fc_bk_idex_o  = 1'b1;
      fc_bk_exmem_o = 1'b1;
    end else if (ex_jump_i) begin
      fc_jump_flag_o  = 1'b1;
      fc_jump_pc_o    = ex_jump_pc_i;
      fc_flush_ifid_o = 1'b1;
      fc_flush_idex_o = 1'b1;
    end else if (w_load_use) begin
      // ID/EX is flushed, not held: bk would win over flush there.
      fc_bk_pc_o      = 1'b1;
      fc_bk_ifid_o    = 1'b1;
      fc_flush_idex_o = 1'b1;
    end
  end

`ifdef FC_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_any_bk;
  logic        w_any_flush;

  assign w_any_bk    = fc_bk_pc_o | fc_bk_ifid_o | fc_bk_idex_o | fc_bk_exmem_o;
  assign w_any_flush = fc_flush_ifid_o | fc_flush_idex_o | fc_flush_exmem_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'h0;
      r_flush_cnt <= 32'h0;
    end else begin
      if (w_any_bk)    r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_any_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign fc_stall_cnt_o = r_stall_cnt;
  assign fc_flush_cnt_o = r_flush_cnt;
`else
  assign fc_stall_cnt_o = 32'h0;
  assign fc_flush_cnt_o = 32'h0;
`endif

endmodule : flow_ctrl
`default_nettype wire

// File: tb/tb_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_flow_ctrl
// Description : Directed self-checking bench for flow_ctrl (MEM_TIMEOUT=4).
//               Control outputs are packed as
//               {bk_pc,bk_ifid,bk_idex,bk_exmem,fl_ifid,fl_idex,fl_exmem,
//                jump_flag,mem_err}. Honours FC_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flow_ctrl;

  localparam logic [8:0] C_NONE  = 9'b0000_000_0_0;
  localparam logic [8:0] C_STALL = 9'b1111_000_0_0;
  localparam logic [8:0] C_LU    = 9'b1100_010_0_0;
  localparam logic [8:0] C_BR    = 9'b0000_110_1_0;
  localparam logic [8:0] C_TO    = 9'b0000_001_0_1;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, waddr;
  logic        re1, re2, mtype, rw, jump, mreq, mack;
  logic [31:0] jpc;
  logic        bk_pc, bk_ifid, bk_idex, bk_exmem;
  logic        fl_ifid, fl_idex, fl_exmem, jflag, merr;
  logic [31:0] jump_pc, stall_cnt, flush_cnt;
  logic [8:0]  ctrl;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign ctrl = {bk_pc, bk_ifid, bk_idex, bk_exmem, fl_ifid, fl_idex, fl_exmem, jflag, merr};

  flow_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1_addr_i    (rs1),
    .id_rs1_re_i      (re1),
    .id_rs2_addr_i    (rs2),
    .id_rs2_re_i      (re2),
    .idex_reg_waddr_i (waddr),
    .idex_mtype_i     (mtype),
    .idex_mem_rw_i    (rw),
    .ex_jump_i        (jump),
    .ex_jump_pc_i     (jpc),
    .mem_req_i        (mreq),
    .mem_ack_i        (mack),
    .fc_bk_pc_o       (bk_pc),
    .fc_bk_ifid_o     (bk_ifid),
    .fc_bk_idex_o     (bk_idex),
    .fc_bk_exmem_o    (bk_exmem),
    .fc_flush_ifid_o  (fl_ifid),
    .fc_flush_idex_o  (fl_idex),
    .fc_flush_exmem_o (fl_exmem),
    .fc_jump_flag_o   (jflag),
    .fc_jump_pc_o     (jump_pc),
    .fc_mem_err_o     (merr),
    .fc_stall_cnt_o   (stall_cnt),
    .fc_flush_cnt_o   (flush_cnt)
  );

  // Sample at the falling edge, mid-cycle, then compare controls and PC.
  task automatic check(input string tag, input logic [8:0] exp_ctrl, input logic [31:0] exp_pc);
    @(negedge clk);
    n_chk++;
    assert (ctrl === exp_ctrl) else begin
      n_fail++;
      $error("FAIL %s ctrl: observed %b expected %b", tag, ctrl, exp_ctrl);
    end
    n_chk++;
    assert (jump_pc === exp_pc) else begin
      n_fail++;
      $error("FAIL %s jump_pc: observed %h expected %h", tag, jump_pc, exp_pc);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] exp_st, input logic [31:0] exp_fl);
    @(negedge clk);
    n_chk++;
    assert (stall_cnt === exp_st) else begin
      n_fail++;
      $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, stall_cnt, exp_st);
    end
    n_chk++;
    assert (flush_cnt === exp_fl) else begin
      n_fail++;
      $error("FAIL %s flush_cnt: observed %0d expected %0d", tag, flush_cnt, exp_fl);
    end
  endtask

  // Advance to just after the next rising edge; inputs change there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1 = 5'd0; rs2 = 5'd0; waddr = 5'd0;
    re1 = 1'b0; re2 = 1'b0; mtype = 1'b0; rw = 1'b0;
    jump = 1'b0; jpc = 32'h0; mreq = 1'b0; mack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    // Reset: outputs forced low even with active inputs.
    jump = 1'b1; jpc = 32'h1234_5678; mreq = 1'b1;
    waddr = 5'd5; mtype = 1'b1; rs1 = 5'd5; re1 = 1'b1;
    check("reset_outputs", C_NONE, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    clear_inputs();
    check("idle_after_reset", C_NONE, 32'h0);
    check_cnt("cnt_after_reset", 32'd0, 32'd0);

    // 1. Load-use on rs2, then bubble cleared next cycle.
    tick();
    mtype = 1'b1; rw = 1'b0; waddr = 5'd5; rs2 = 5'd5; re2 = 1'b1;
    check("lu_rs2", C_LU, 32'h0);
    tick();
    mtype = 1'b0;
    check("lu_released", C_NONE, 32'h0);
    tick();
    mtype = 1'b1; rs2 = 5'd0; re2 = 1'b0; rs1 = 5'd5; re1 = 1'b1;
    check("lu_rs1", C_LU, 32'h0);
    tick();
    re1 = 1'b0;
    check("lu_rs1_no_re", C_NONE, 32'h0);

    // 2. x0 destination and store never stall.
    tick();
    waddr = 5'd0; rs1 = 5'd0; re1 = 1'b1;
    check("lu_x0", C_NONE, 32'h0);
    tick();
    waddr = 5'd5; rs1 = 5'd5; rw = 1'b1;
    check("lu_store", C_NONE, 32'h0);

    // 3. Branch with simultaneous load-use.
    tick();
    rw = 1'b0; rs1 = 5'd0; re1 = 1'b0; rs2 = 5'd5; re2 = 1'b1;
    jump = 1'b1; jpc = 32'h0000_0100;
    check("branch_over_lu", C_BR, 32'h0000_0100);
    tick();
    clear_inputs();
    jpc = 32'hDEAD_BEEF;
    check("no_jump_pc_zero", C_NONE, 32'h0);

    // 4. Memory wait, ack in 4th cycle, jump ignored while stalled.
    tick();
    clear_inputs();
    do_reset();
    mreq = 1'b1;
    check("mw_c1", C_STALL, 32'h0);
    tick();
    jump = 1'b1; jpc = 32'h0000_0200;
    check("mw_c2_jump_ignored", C_STALL, 32'h0);
    tick();
    check("mw_c3_jump_ignored", C_STALL, 32'h0);
    tick();
    jump = 1'b0; mack = 1'b1;
    check("mw_ack", C_NONE, 32'h0);
    tick();
    mreq = 1'b0; mack = 1'b0;
    check("mw_back_idle", C_NONE, 32'h0);
`ifdef FC_PERF_CNT_EN
    check_cnt("cnt_after_mw", 32'd3, 32'd0);
`else
    check_cnt("cnt_after_mw", 32'd0, 32'd0);
`endif

    // 4b. Jump held across the ack cycle takes effect on release.
    tick();
    mreq = 1'b1; jump = 1'b1; jpc = 32'h0000_0200;
    check("mw2_stall", C_STALL, 32'h0);
    tick();
    mack = 1'b1;
    check("mw2_ack_jump", C_BR, 32'h0000_0200);

    // 5. Timeout with MEM_TIMEOUT=4: IDLE request cycle + MEM_WAIT cnt 1..3 stall,
    //    cnt 4 aborts.
    tick();
    clear_inputs();
    mreq = 1'b1;
    check("to_idle_req", C_STALL, 32'h0);
    tick();
    check("to_cnt1", C_STALL, 32'h0);
    tick();
    check("to_cnt2", C_STALL, 32'h0);
    tick();
    check("to_cnt3", C_STALL, 32'h0);
    tick();
    check("to_abort", C_TO, 32'h0);
    tick();
    mreq = 1'b0;
    check("to_back_idle", C_NONE, 32'h0);

    // 6. Reset during MEM_WAIT: no error pulse afterwards.
    tick();
    mreq = 1'b1;
    check("rst_mw_c1", C_STALL, 32'h0);
    tick();
    check("rst_mw_c2", C_STALL, 32'h0);
    tick();
    rst = 1'b1;
    check("rst_mw_forced", C_NONE, 32'h0);
    tick();
    rst = 1'b0; mreq = 1'b0;
    check("rst_mw_idle", C_NONE, 32'h0);
    check_cnt("cnt_after_rst", 32'd0, 32'd0);
    tick();
    check("rst_mw_no_err", C_NONE, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_flow_ctrl
`default_nettype wire
